// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter slice.
//   word_t      - 32-bit data/address word
//   ramstate_t  - RAM port status (FREE/BUSY/ACCESS/ERROR)
//   arb_state_t - arbiter FSM state register type
// Also holds the default starvation and timeout limits.
package mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;

    typedef logic [1:0] arb_state_t;

    localparam int ISTARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF     = 64;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the cache controllers, the arbiter and the single-port RAM.
//   icache side : iren, iaddr -> / <- iload, iwait
//   dcache side : dren, dwen, daddr, dstore -> / <- dload, dwait
//   RAM side    : <- ram_ren, ram_wen, ram_addr, ram_store / -> ram_load, ram_state
// slave  : the arbiter's view.
// master : the view of whatever drives the caches and models the RAM.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic      iren;
    word_t     iaddr;
    word_t     iload;
    logic      iwait;

    logic      dren;
    logic      dwen;
    word_t     daddr;
    word_t     dstore;
    word_t     dload;
    logic      dwait;

    logic      ram_ren;
    logic      ram_wen;
    word_t     ram_addr;
    word_t     ram_store;
    word_t     ram_load;
    ramstate_t ram_state;

    modport slave (
        input  iren, iaddr, dren, dwen, daddr, dstore, ram_load, ram_state,
        output iload, iwait, dload, dwait, ram_ren, ram_wen, ram_addr, ram_store
    );

    modport master (
        output iren, iaddr, dren, dwen, daddr, dstore, ram_load, ram_state,
        input  iload, iwait, dload, dwait, ram_ren, ram_wen, ram_addr, ram_store
    );

endinterface

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock and synchronous active-high reset
//   en       : count up by one (held at MAX once reached)
//   clr      : synchronous clear, wins over en
//   sat      : high while the count equals MAX
module mem_arbiter_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic sat
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !sat) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between icache fetches and dcache word transfers for one RAM port.
//   clk, rst : clock and synchronous active-high reset
//   bus      : cache-side requests/handshakes and RAM-side strobes/status
//   err_flag : sticky, set when any granted access completes with ERROR
//   tmo_flag : sticky, set when a granted access has waited TIMEOUT cycles
// Dcache has priority; after ISTARVE_MAX back-to-back dcache completions
// with an icache request pending, the icache is granted next.
//
// state    | meaning
// ST_IDLE  | no grant, arbitrate on this cycle's requests
// ST_DSERV | dcache owns the RAM port until ACCESS/ERROR or request drop
// ST_ISERV | icache owns the RAM port until ACCESS/ERROR or request drop
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ISTARVE_MAX = ISTARVE_MAX_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic         err_flag,
    output logic         tmo_flag
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DSERV = 2'd1;
    localparam logic [1:0] ST_ISERV = 2'd2;

    localparam int SW = $clog2(ISTARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t state;
    arb_state_t state_next;

    logic d_req;
    logic ram_done;
    logic d_done;
    logic i_done;
    logic force_i;
    logic starve_sat;
    logic tmo_sat;

    assign d_req    = bus.dren | bus.dwen;
    assign ram_done = (bus.ram_state == RAM_ACCESS) | (bus.ram_state == RAM_ERROR);
    assign d_done   = (state == ST_DSERV) & ram_done;
    assign i_done   = (state == ST_ISERV) & ram_done;
    assign force_i  = bus.iren & starve_sat;

    // Starvation count: dcache completions that left a pending fetch waiting.
    mem_arbiter_sat_counter #(
        .WIDTH (SW),
        .MAX   (ISTARVE_MAX)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .en  (d_done & bus.iren),
        .clr (i_done | ~bus.iren),
        .sat (starve_sat)
    );

    // Cycles spent holding a grant; cleared whenever the FSM lands in IDLE.
    mem_arbiter_sat_counter #(
        .WIDTH (TW),
        .MAX   (TIMEOUT)
    ) u_tmo (
        .clk (clk),
        .rst (rst),
        .en  (state != ST_IDLE),
        .clr (state_next == ST_IDLE),
        .sat (tmo_sat)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (d_req && !force_i) begin
                    state_next = ST_DSERV;
                end else if (bus.iren) begin
                    state_next = ST_ISERV;
                end
            end
            ST_DSERV: begin
                if (ram_done || !d_req) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ISERV: begin
                if (ram_done || !bus.iren) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // RAM drive follows the live request of the current owner, so a dropped
    // request removes the strobe in the same cycle; a write beats a read.
    always_comb begin
        bus.ram_ren   = 1'b0;
        bus.ram_wen   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_store = '0;
        case (state)
            ST_DSERV: begin
                bus.ram_wen   = bus.dwen;
                bus.ram_ren   = bus.dren & ~bus.dwen;
                bus.ram_addr  = bus.daddr;
                bus.ram_store = bus.dstore;
            end
            ST_ISERV: begin
                bus.ram_ren  = bus.iren;
                bus.ram_addr = bus.iaddr;
            end
            default: ;
        endcase
    end

    assign bus.dwait = ~d_done;
    assign bus.iwait = ~i_done;
    assign bus.dload = bus.ram_load;
    assign bus.iload = bus.ram_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            err_flag <= 1'b0;
            tmo_flag <= 1'b0;
        end else begin
            state <= state_next;
            if ((d_done || i_done) && bus.ram_state == RAM_ERROR) begin
                err_flag <= 1'b1;
            end
            if (tmo_sat) begin
                tmo_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural model of the arbiter.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int ISTARVE_MAX = 4;
    localparam int TIMEOUT     = 64;

    logic clk = 1'b0;
    logic rst;
    logic err_flag;
    logic tmo_flag;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .ISTARVE_MAX (ISTARVE_MAX),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .err_flag (err_flag),
        .tmo_flag (tmo_flag)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: who holds the RAM (0 none, 1 dcache, 2 icache),
    // how many dcache wins starved a pending fetch, cycles held so far.
    int owner;
    int starve;
    int waited;
    bit m_err;
    bit m_tmo;

    int d_lows;
    int i_lows;
    int grants[$];
    logic        s_ren, s_wen, s_iwait, s_dwait, s_err, s_tmo;
    logic [31:0] s_addr, s_store, low_iload;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic ramstate_t pick_rs();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 4) return RAM_BUSY;
        if (r < 7) return RAM_ACCESS;
        if (r < 9) return RAM_FREE;
        return RAM_ERROR;
    endfunction

    // Compare the settled outputs of the current cycle, then advance the model
    // across the clock edge using the same inputs the DUT sampled.
    task automatic step();
        bit          done, dreq;
        int          nxt;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        #2;
        done    = (owner != 0) && (bus.ram_state == RAM_ACCESS || bus.ram_state == RAM_ERROR);
        dreq    = bus.dren | bus.dwen;
        e_ren   = 1'b0;
        e_wen   = 1'b0;
        e_addr  = 32'h0;
        e_store = 32'h0;
        if (owner == 1) begin
            e_wen   = bus.dwen;
            e_ren   = bus.dren & ~bus.dwen;
            e_addr  = bus.daddr;
            e_store = bus.dstore;
        end else if (owner == 2) begin
            e_ren  = bus.iren;
            e_addr = bus.iaddr;
        end
        chk("ram_ren", {31'b0, bus.ram_ren}, {31'b0, e_ren});
        chk("ram_wen", {31'b0, bus.ram_wen}, {31'b0, e_wen});
        chk("ram_addr", bus.ram_addr, e_addr);
        chk("ram_store", bus.ram_store, e_store);
        chk("dwait", {31'b0, bus.dwait}, {31'b0, !(owner == 1 && done)});
        chk("iwait", {31'b0, bus.iwait}, {31'b0, !(owner == 2 && done)});
        chk("iload", bus.iload, bus.ram_load);
        chk("dload", bus.dload, bus.ram_load);
        chk("err_flag", {31'b0, err_flag}, {31'b0, m_err});
        chk("tmo_flag", {31'b0, tmo_flag}, {31'b0, m_tmo});

        s_ren   = bus.ram_ren;
        s_wen   = bus.ram_wen;
        s_addr  = bus.ram_addr;
        s_store = bus.ram_store;
        s_iwait = bus.iwait;
        s_dwait = bus.dwait;
        s_err   = err_flag;
        s_tmo   = tmo_flag;
        if (!bus.dwait) begin
            d_lows++;
            grants.push_back(1);
        end
        if (!bus.iwait) begin
            i_lows++;
            grants.push_back(2);
            low_iload = bus.iload;
        end

        @(posedge clk);
        if (rst) begin
            owner  = 0;
            starve = 0;
            waited = 0;
            m_err  = 1'b0;
            m_tmo  = 1'b0;
        end else begin
            nxt = owner;
            if (waited >= TIMEOUT) m_tmo = 1'b1;
            if (owner == 0) begin
                if (dreq && !(bus.iren && starve == ISTARVE_MAX)) nxt = 1;
                else if (bus.iren) nxt = 2;
            end else if (done || (owner == 1 ? !dreq : !bus.iren)) begin
                nxt = 0;
            end
            if (done && bus.ram_state == RAM_ERROR) m_err = 1'b1;
            if (!bus.iren || (owner == 2 && done)) starve = 0;
            else if (owner == 1 && done && starve < ISTARVE_MAX) starve++;
            if (nxt == 0) waited = 0;
            else if (owner != 0 && waited < TIMEOUT) waited++;
            owner = nxt;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.iren      = 1'b0;
        bus.dren      = 1'b0;
        bus.dwen      = 1'b0;
        bus.ram_state = RAM_FREE;
    endtask

    int exp_g[6] = '{1, 1, 1, 1, 2, 1};
    int first_tmo;

    initial begin
        rst           = 1'b1;
        idle_inputs();
        bus.iaddr     = 32'h0;
        bus.daddr     = 32'h0;
        bus.dstore    = 32'h0;
        bus.ram_load  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        owner = 0; starve = 0; waited = 0; m_err = 1'b0; m_tmo = 1'b0;
        d_lows = 0; i_lows = 0;
        rst = 1'b0;

        // Reset state
        step();
        chk("rst_ren", {31'b0, s_ren}, 32'd0);
        chk("rst_wen", {31'b0, s_wen}, 32'd0);
        chk("rst_addr", s_addr, 32'h0);
        chk("rst_store", s_store, 32'h0);
        chk("rst_waits", {30'b0, s_iwait, s_dwait}, 32'd3);
        chk("rst_flags", {30'b0, s_err, s_tmo}, 32'd0);

        // Fetch only: BUSY twice then ACCESS
        d_lows = 0; i_lows = 0;
        bus.iren = 1'b1; bus.iaddr = 32'h40; bus.ram_state = RAM_BUSY;
        step();
        step();
        chk("fetch_addr", s_addr, 32'h40);
        step();
        bus.ram_state = RAM_ACCESS; bus.ram_load = 32'hDEADBEEF;
        step();
        bus.iren = 1'b0; bus.ram_state = RAM_FREE;
        step();
        step();
        chk("fetch_ilows", i_lows, 32'd1);
        chk("fetch_dlows", d_lows, 32'd0);
        chk("fetch_iload", low_iload, 32'hDEADBEEF);

        // Conflict with 1-cycle RAM: four dcache grants, one icache, dcache again
        grants.delete();
        bus.iren = 1'b1; bus.dren = 1'b1; bus.ram_state = RAM_ACCESS;
        repeat (12) step();
        for (int i = 0; i < 6; i++)
            chk("conflict_grant", (i < grants.size()) ? grants[i] : 0, exp_g[i]);
        idle_inputs();
        step();

        // Write
        d_lows = 0;
        bus.dwen = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'h12345678; bus.ram_state = RAM_BUSY;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wr_wen", {31'b0, s_wen}, 32'd1);
            chk("wr_ren", {31'b0, s_ren}, 32'd0);
            chk("wr_addr", s_addr, 32'h100);
            chk("wr_store", s_store, 32'h12345678);
        end
        bus.ram_state = RAM_ACCESS;
        step();
        idle_inputs();
        step();
        chk("wr_dlows", d_lows, 32'd1);

        // Abort: dcache read dropped while BUSY
        d_lows = 0;
        bus.dren = 1'b1; bus.ram_state = RAM_BUSY;
        step();
        step();
        chk("abort_ren_on", {31'b0, s_ren}, 32'd1);
        bus.dren = 1'b0;
        step();
        step();
        chk("abort_ren_off", {31'b0, s_ren}, 32'd0);
        chk("abort_dlows", d_lows, 32'd0);

        // ERROR completion on a fetch
        i_lows = 0;
        bus.iren = 1'b1; bus.ram_state = RAM_ERROR;
        step();
        step();
        idle_inputs();
        step();
        step();
        chk("err_ilows", i_lows, 32'd1);
        chk("err_sticky", {31'b0, s_err}, 32'd1);

        // Timeout: hold BUSY, reset mid-access
        first_tmo = 0;
        bus.dren = 1'b1; bus.ram_state = RAM_BUSY;
        step();
        for (int k = 1; k <= 65; k++) begin
            step();
            if (s_tmo && first_tmo == 0) first_tmo = k;
        end
        rst = 1'b1;
        step();
        if (s_tmo && first_tmo == 0) first_tmo = 66;
        chk("tmo_first_cycle", first_tmo, 32'd66);
        rst = 1'b0;
        step();
        chk("rst_mid_ren", {31'b0, s_ren}, 32'd0);
        chk("rst_mid_flags", {30'b0, s_err, s_tmo}, 32'd0);
        chk("rst_mid_addr", s_addr, 32'h0);
        idle_inputs();
        step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) bus.iren = ~bus.iren;
            if ($urandom_range(0, 5) == 0) bus.dren = ~bus.dren;
            if ($urandom_range(0, 9) == 0) bus.dwen = ~bus.dwen;
            bus.iaddr     = $urandom;
            bus.daddr     = $urandom;
            bus.dstore    = $urandom;
            bus.ram_load  = $urandom;
            bus.ram_state = pick_rs();
            rst           = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
